gobang_move_writer: RTL and testbench
=====================================

Name: gobang_move_writer

Overview:
- Move-commit controller for the 15x15 gobang board; the writer side of the win-checker interface.
- Accepts placement requests, rejects illegal cells, and writes stones into per-player 225-bit occupancy maps.
- Presents the mover's map plus last row/col to the combinational win checker, samples its verdict, then alternates players or ends the game (win/draw).

Parameters:
N, 15, board edge length; row/col legal range 0..N-1
CELLS, 225, N*N, width of each board map
CNT_W, 8, width of move counter (must hold CELLS)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
place  input  1  placement request, sampled in IDLE only
row  input  4  requested row
col  input  4  requested column
restart  input  1  synchronous new-game request, any state
win_in  input  1  verdict from win checker for chk_board/chk_row/chk_col
black_board  output  225  black stone map, bit row*N+col
white_board  output  225  white stone map
chk_board  output  225  map of the side that just moved (to checker)
chk_row  output  4  row of last accepted move (to checker)
chk_col  output  4  column of last accepted move (to checker)
player  output  1  side to move: 0 black, 1 white
busy  output  1  high in SETTLE and JUDGE
reject  output  1  one-cycle pulse on illegal request
game_over  output  1  high in OVER
winner  output  1  side that won; valid when game_over and !draw
draw  output  1  high in OVER when board filled without win

Behaviour:
- Reset (rst_n low, async): both boards 0, chk_row/chk_col 0, player 0, move_count 0, state IDLE, busy/reject/game_over/winner/draw 0.
- Index rule: bit = row*15+col, row-major, bit 0 = (0,0); 4-bit operands are extended to 8 bits before multiply, with no truncation.
- chk_board mux: player 0 -> black_board, player 1 -> white_board. Player is unchanged until JUDGE completes.
- State IDLE, place=1:
  - row>14 or col>14 -> reject=1 next cycle, stay IDLE, no state change.
  - Cell occupied in either map -> reject=1, stay IDLE.
  - Otherwise, at that edge: set bit in the current player's map, latch chk_row/chk_col, move_count+1, go SETTLE.
- SETTLE: one cycle for checker settling; win_in is ignored.
- JUDGE: win_in is sampled at the closing edge.
  - win_in=1 -> OVER, winner=player, draw=0.
  - Else move_count==225 -> OVER, draw=1.
  - Else toggle player, go IDLE.
- Latency: place accepted at edge k; map bit visible after k; verdict registered at k+2; next place accepted at k+3 earliest.
- OVER: place is ignored with no reject; all outputs hold.
- place during SETTLE/JUDGE: ignored, no reject, no queueing.
- restart=1 (any state, sync): same values as reset, go IDLE; has priority over place and over the JUDGE outcome in the same cycle.
- reject is high only for the single cycle after the illegal request.
- win_in high outside JUDGE has no effect.

Test Plan:
- Reset then place (7,7): black_board bit 112 set, chk_row=7/chk_col=7, busy high 2 cycles, win_in=0 -> player=1, move_count=1.
- White places (7,7) again: reject pulse 1 cycle, white_board unchanged, player stays 1, state IDLE.
- place row=15 col=3: reject pulse, no map change; place during busy: ignored, no reject.
- Black plays (0,0)..(0,4), white plays elsewhere, win_in forced 1 at JUDGE of 5th black move: game_over=1, winner=0; further place ignored.
- Fill all 225 cells with win_in=0: after 225th JUDGE, game_over=1, draw=1.
- restart asserted in JUDGE with win_in=1: next cycle both maps 0, player 0, game_over 0; async rst_n low mid-SETTLE clears all immediately.

Source files
------------

// File: rtl/gobang_move_writer_if.sv
// rtl/gobang_move_writer_if.sv - request/checker/board bundle for the gobang move writer
//
// Ports (signals):
//   place/row/col/restart  - placement and new-game requests (master -> slave)
//   win_in                 - win checker verdict for chk_board/chk_row/chk_col (master -> slave)
//   black_board/white_board- per-player occupancy maps, bit row*N+col (slave -> master)
//   chk_board/chk_row/chk_col - mover's map and last move, to the win checker (slave -> master)
//   player/busy/reject/game_over/winner/draw - game status (slave -> master)
interface gobang_move_writer_if #(
    parameter int CELLS = 225
) ();
    logic             place;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             restart;
    logic             win_in;
    logic [CELLS-1:0] black_board;
    logic [CELLS-1:0] white_board;
    logic [CELLS-1:0] chk_board;
    logic [3:0]       chk_row;
    logic [3:0]       chk_col;
    logic             player;
    logic             busy;
    logic             reject;
    logic             game_over;
    logic             winner;
    logic             draw;

    modport master (
        output place, row, col, restart, win_in,
        input  black_board, white_board, chk_board, chk_row, chk_col,
        input  player, busy, reject, game_over, winner, draw
    );

    modport slave (
        input  place, row, col, restart, win_in,
        output black_board, white_board, chk_board, chk_row, chk_col,
        output player, busy, reject, game_over, winner, draw
    );
endinterface

// File: rtl/gobang_move_writer.sv
// rtl/gobang_move_writer.sv - move-commit controller writing stones into per-player board maps
//
// Ports:
//   clk    - system clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - gobang_move_writer_if.slave: requests in, board maps / checker feed / status out
module gobang_move_writer #(
    parameter int N     = 15,
    parameter int CELLS = 225,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gobang_move_writer_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_JUDGE  = 2'd2;
    localparam logic [1:0] S_OVER   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] move_count;
    logic [CELLS-1:0] black_q;
    logic [CELLS-1:0] white_q;
    logic [3:0]       row_q;
    logic [3:0]       col_q;
    logic             player_q;
    logic             reject_q;
    logic             winner_q;
    logic             draw_q;

    logic [7:0]       cell_idx;
    logic [CELLS-1:0] cell_mask;
    logic             in_range;
    logic             occupied;

    // Operands widened to 8 bits so row*N+col never truncates (max 15*15+15).
    assign cell_idx  = {4'd0, bus.row} * 8'(N) + {4'd0, bus.col};
    assign in_range  = (bus.row < 4'(N)) && (bus.col < 4'(N));
    // Shift past the top bit yields an all-zero mask; in_range gates that case anyway.
    assign cell_mask = {{(CELLS-1){1'b0}}, 1'b1} << cell_idx;
    assign occupied  = |((black_q | white_q) & cell_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            move_count <= '0;
            black_q    <= '0;
            white_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            player_q   <= 1'b0;
            reject_q   <= 1'b0;
            winner_q   <= 1'b0;
            draw_q     <= 1'b0;
        end else if (bus.restart) begin
            // New game wins over any pending placement or verdict this cycle.
            state      <= S_IDLE;
            move_count <= '0;
            black_q    <= '0;
            white_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            player_q   <= 1'b0;
            reject_q   <= 1'b0;
            winner_q   <= 1'b0;
            draw_q     <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.place) begin
                        if (!in_range || occupied) begin
                            reject_q <= 1'b1;
                        end else begin
                            if (player_q) begin
                                white_q <= white_q | cell_mask;
                            end else begin
                                black_q <= black_q | cell_mask;
                            end
                            row_q      <= bus.row;
                            col_q      <= bus.col;
                            move_count <= move_count + CNT_W'(1);
                            state      <= S_SETTLE;
                        end
                    end
                end
                // Gives the combinational checker a full cycle on the new map.
                S_SETTLE: state <= S_JUDGE;
                S_JUDGE: begin
                    if (bus.win_in) begin
                        state    <= S_OVER;
                        winner_q <= player_q;
                        draw_q   <= 1'b0;
                    end else if (move_count == CNT_W'(CELLS)) begin
                        state  <= S_OVER;
                        draw_q <= 1'b1;
                    end else begin
                        player_q <= ~player_q;
                        state    <= S_IDLE;
                    end
                end
                S_OVER:  state <= S_OVER;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.black_board = black_q;
    assign bus.white_board = white_q;
    // Player only flips after the verdict, so this is the mover's map throughout SETTLE/JUDGE.
    assign bus.chk_board   = player_q ? white_q : black_q;
    assign bus.chk_row     = row_q;
    assign bus.chk_col     = col_q;
    assign bus.player      = player_q;
    assign bus.busy        = (state == S_SETTLE) || (state == S_JUDGE);
    assign bus.reject      = reject_q;
    assign bus.game_over   = (state == S_OVER);
    assign bus.winner      = winner_q;
    assign bus.draw        = draw_q;
endmodule

// File: tb/tb_gobang_move_writer.sv
// tb/tb_gobang_move_writer.sv - self-checking bench for gobang_move_writer against a board-array model
module tb_gobang_move_writer;
    localparam int N     = 15;
    localparam int CELLS = 225;

    logic clk;
    logic rst_n;

    gobang_move_writer_if #(.CELLS(CELLS)) bus ();

    gobang_move_writer #(.N(N), .CELLS(CELLS), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: owner per cell (0 empty, 1 black, 2 white) plus game status.
    int occ [CELLS];
    int m_player;
    int m_count;
    int m_over;
    int m_winner;
    int m_draw;
    int last_r;
    int last_c;

    task automatic model_clear();
        for (int i = 0; i < CELLS; i++) occ[i] = 0;
        m_player = 0; m_count = 0; m_over = 0; m_winner = 0; m_draw = 0;
        last_r = 0; last_c = 0;
    endtask

    function automatic logic [CELLS-1:0] map_of(input int who);
        logic [CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (occ[r*N+c] == who) m[r*N+c] = 1'b1;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy, input logic exp_rej);
        chk({tag, ".black"},     256'(bus.black_board), 256'(map_of(1)));
        chk({tag, ".white"},     256'(bus.white_board), 256'(map_of(2)));
        chk({tag, ".chk_board"}, 256'(bus.chk_board),   256'(map_of(m_player + 1)));
        chk({tag, ".chk_row"},   256'(bus.chk_row),     256'(last_r));
        chk({tag, ".chk_col"},   256'(bus.chk_col),     256'(last_c));
        chk({tag, ".player"},    256'(bus.player),      256'(m_player));
        chk({tag, ".busy"},      256'(bus.busy),        256'(exp_busy));
        chk({tag, ".reject"},    256'(bus.reject),      256'(exp_rej));
        chk({tag, ".game_over"}, 256'(bus.game_over),   256'(m_over));
        chk({tag, ".winner"},    256'(bus.winner),      256'(m_winner));
        chk({tag, ".draw"},      256'(bus.draw),        256'(m_draw));
    endtask

    // One placement attempt from IDLE (or OVER), following it to the verdict when accepted.
    task automatic do_place(input int r, input int c, input logic w);
        bit legal;
        bus.place  = 1'b1;
        bus.row    = 4'(r);
        bus.col    = 4'(c);
        bus.win_in = 1'($urandom);
        tick();
        bus.place  = 1'b0;
        bus.win_in = 1'b0;
        if (m_over != 0) begin
            check_all("over_ignore", 1'b0, 1'b0);
            return;
        end
        legal = (r < N) && (c < N) && (occ[r*N+c] == 0);
        if (!legal) begin
            check_all("reject", 1'b0, 1'b1);
            tick();
            check_all("reject_end", 1'b0, 1'b0);
            return;
        end
        occ[r*N+c] = m_player + 1;
        m_count++;
        last_r = r;
        last_c = c;
        check_all("settle", 1'b1, 1'b0);
        // A request while busy must be dropped without a reject.
        bus.place  = 1'b1;
        bus.row    = 4'($urandom_range(0, 15));
        bus.col    = 4'($urandom_range(0, 15));
        bus.win_in = 1'($urandom);
        tick();
        bus.place  = 1'b0;
        check_all("judge", 1'b1, 1'b0);
        bus.win_in = w;
        tick();
        bus.win_in = 1'b0;
        if (w) begin
            m_over = 1; m_winner = m_player; m_draw = 0;
        end else if (m_count == CELLS) begin
            m_over = 1; m_draw = 1;
        end else begin
            m_player = 1 - m_player;
        end
        check_all("verdict", 1'b0, 1'b0);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
        model_clear();
        check_all("restart", 1'b0, 1'b0);
    endtask

    int perm [CELLS];

    initial begin
        rst_n       = 1'b0;
        bus.place   = 1'b0;
        bus.row     = '0;
        bus.col     = '0;
        bus.restart = 1'b0;
        bus.win_in  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("post_reset", 1'b0, 1'b0);

        // First move, repeat on same cell by white, out-of-range requests.
        do_place(7, 7, 1'b0);
        chk("bit112", 256'(bus.black_board[112]), 256'(1));
        do_place(7, 7, 1'b0);
        do_place(15, 3, 1'b0);
        do_place(3, 15, 1'b0);
        do_place(15, 15, 1'b0);

        // Black wins along row 0.
        do_restart();
        for (int k = 0; k < 5; k++) begin
            do_place(0, k, (k == 4) ? 1'b1 : 1'b0);
            if (k < 4) do_place(5, k, 1'b0);
        end
        chk("black_win_over", 256'(bus.game_over), 256'(1));
        do_place(9, 9, 1'b0);
        do_place(0, 0, 1'b0);
        tick();
        check_all("over_hold", 1'b0, 1'b0);

        // Random fill to a draw, with random extra (possibly illegal) requests mixed in.
        do_restart();
        for (int i = 0; i < CELLS; i++) perm[i] = i;
        for (int i = CELLS - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < CELLS; i++) begin
            if (m_over == 0 && $urandom_range(0, 3) == 0)
                do_place($urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
            if (m_over == 0 && occ[perm[i]] == 0)
                do_place(perm[i] / N, perm[i] % N, 1'b0);
        end
        chk("draw_reached", 256'(bus.draw), 256'(1));
        chk("draw_over",    256'(bus.game_over), 256'(1));
        do_place(2, 2, 1'b0);

        // Restart during JUDGE overrides a winning verdict.
        do_restart();
        bus.place = 1'b1; bus.row = 4'd6; bus.col = 4'd9;
        tick();
        bus.place = 1'b0;
        chk("rj_settle_busy", 256'(bus.busy), 256'(1));
        tick();
        chk("rj_judge_busy", 256'(bus.busy), 256'(1));
        bus.restart = 1'b1; bus.win_in = 1'b1; bus.place = 1'b1;
        tick();
        bus.restart = 1'b0; bus.win_in = 1'b0; bus.place = 1'b0;
        model_clear();
        check_all("restart_in_judge", 1'b0, 1'b0);

        // Async reset in the middle of SETTLE clears without a clock edge.
        do_place(1, 1, 1'b0);
        bus.place = 1'b1; bus.row = 4'd3; bus.col = 4'd4;
        tick();
        bus.place = 1'b0;
        chk("ar_settle_busy", 256'(bus.busy), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("after_async", 1'b0, 1'b0);
        do_place(14, 14, 1'b0);
        chk("bit224", 256'(bus.black_board[224]), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
